// File: rtl/nonce_scheduler.sv
// Work-unit sequencer for the SHA-256 double-hash pipeline: issues one nonce per cycle,
// waits out the hasher latency, and buffers golden-nonce hits for the UART transmitter.
module nonce_scheduler #(
    parameter int          PIPE_LAT   = 130,
    parameter logic [31:0] NONCE_LAST = 32'hFFFFFFFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    output logic         hash_valid,
    output logic [255:0] hash_midstate,
    output logic [95:0]  hash_data,
    output logic [31:0]  hash_nonce,
    input  logic         hit_valid,
    input  logic [31:0]  hit_nonce,
    output logic         gold_valid,
    input  logic         gold_ready,
    output logic [31:0]  gold_nonce,
    output logic         busy,
    output logic         exhausted,
    output logic         overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t         r_state;
    logic           r_workReady;
    logic           r_hashValid;
    logic [255:0]   r_midstate;
    logic [95:0]    r_data;
    logic [31:0]    r_nonce;
    logic [CW-1:0]  r_drainCnt;
    logic           r_busy;
    logic           r_exhausted;
    logic           r_overflow;

    logic [31:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0]  r_wrPtr;
    logic [PW-1:0]  r_rdPtr;
    logic           r_goldValid;
    logic [31:0]    r_goldNonce;

    logic           w_accept;
    logic           w_fifoFull;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic [PW-1:0]  w_wrNext;
    logic [PW-1:0]  w_rdNext;
    logic [31:0]    w_headNext;

    assign w_accept   = work_valid & r_workReady;
    assign w_fifoFull = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                        (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_pop      = r_goldValid & gold_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign w_push     = hit_valid & (~w_fifoFull | w_pop);
    assign w_drop     = hit_valid & w_fifoFull & ~w_pop;
    assign w_wrNext   = w_push ? r_wrPtr + PW'(1) : r_wrPtr;
    assign w_rdNext   = w_pop  ? r_rdPtr + PW'(1) : r_rdPtr;
    assign w_headNext = (w_push && (w_rdNext == r_wrPtr)) ? hit_nonce
                                                          : r_mem[w_rdNext[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_workReady <= 1'b0;
            r_hashValid <= 1'b0;
            r_midstate  <= '0;
            r_data      <= '0;
            r_nonce     <= '0;
            r_drainCnt  <= '0;
            r_busy      <= 1'b0;
            r_exhausted <= 1'b0;
        end else begin
            r_workReady <= 1'b1;
            if (w_accept) begin
                r_state     <= ST_RUN;
                r_hashValid <= 1'b1;
                r_midstate  <= work_midstate;
                r_data      <= work_data;
                r_nonce     <= '0;
                r_busy      <= 1'b1;
                r_exhausted <= 1'b0;
            end else begin
                unique case (r_state)
                    // Compare before incrementing so an all-ones last nonce never wraps.
                    ST_RUN: begin
                        if (r_nonce == NONCE_LAST) begin
                            r_state     <= ST_DRAIN;
                            r_hashValid <= 1'b0;
                            r_drainCnt  <= CW'(PIPE_LAT);
                        end else begin
                            r_nonce <= r_nonce + 32'd1;
                        end
                    end
                    ST_DRAIN: begin
                        if (r_drainCnt == '0) begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_exhausted <= 1'b1;
                        end else begin
                            r_drainCnt <= r_drainCnt - CW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= hit_nonce;
        end
    end

    // Head entry and valid are registered from the next-state pointers, so an
    // empty FIFO shows a new hit one cycle after it is pushed.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_goldValid <= 1'b0;
            r_goldNonce <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_wrPtr     <= w_wrNext;
            r_rdPtr     <= w_rdNext;
            r_goldValid <= (w_wrNext != w_rdNext);
            if (w_wrNext != w_rdNext) begin
                r_goldNonce <= w_headNext;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_accept) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign work_ready    = r_workReady;
    assign hash_valid    = r_hashValid;
    assign hash_midstate = r_midstate;
    assign hash_data     = r_data;
    assign hash_nonce    = r_nonce;
    assign gold_valid    = r_goldValid;
    assign gold_nonce    = r_goldNonce;
    assign busy          = r_busy;
    assign exhausted     = r_exhausted;
    assign overflow      = r_overflow;

endmodule
